// File: rtl/tl_pkg.sv
// Shared types for the traffic-lamp monitor: lamp encoding, phases, fault codes, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tl_pkg;

  localparam int unsigned YELLOW_CYCLES_DEF = 2;
  localparam int unsigned MAX_GREEN_DEF     = 15;
  localparam int unsigned ARM_CYCLES_DEF    = 2;

  // Lamp bit positions within one light's 3-bit drive word.
  localparam int unsigned BIT_RED    = 0;
  localparam int unsigned BIT_YELLOW = 1;
  localparam int unsigned BIT_GREEN  = 2;

  localparam logic [2:0] LAMP_RED    = 3'(1 << BIT_RED);
  localparam logic [2:0] LAMP_YELLOW = 3'(1 << BIT_YELLOW);
  localparam logic [2:0] LAMP_GREEN  = 3'(1 << BIT_GREEN);

  typedef enum logic [2:0] {
    PH_RED,
    PH_YELLOW,
    PH_GREEN,
    PH_DARK,
    PH_ILLEGAL
  } phase_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_LAMP     = 3'd1,  // illegal or dark lamp word
    FC_CONFLICT = 3'd2,  // more than one light showing green/yellow
    FC_SEQUENCE = 3'd3,  // transition outside red->green->yellow->red
    FC_YELLOW   = 3'd4,  // yellow left after the wrong dwell
    FC_GREEN    = 3'd5   // green held too long
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_ARMING,
    ST_MONITOR,
    ST_FAULT
  } state_e;

  function automatic phase_e decode_lamp(input logic [2:0] lamp);
    if (lamp == LAMP_RED)         decode_lamp = PH_RED;
    else if (lamp == LAMP_YELLOW) decode_lamp = PH_YELLOW;
    else if (lamp == LAMP_GREEN)  decode_lamp = PH_GREEN;
    else if (lamp == 3'b000)      decode_lamp = PH_DARK;
    else                          decode_lamp = PH_ILLEGAL;
  endfunction

  // Index of the lowest set bit; 0 when none set.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    first_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) first_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/lamp_channel.sv
// One light: phase decode, dwell counter, previous phase, and the per-light checks.
// Latency: checks are combinational on the current lamp word against registered history.
// Backpressure: none; samples every cycle.
// Ports: clk, rst (sync, active-low), lamp[2:0] in; phase, err_lamp, err_seq,
//        err_yellow, err_green out (unqualified by FSM state).
module lamp_channel
  import tl_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES = YELLOW_CYCLES_DEF,
  parameter int unsigned MAX_GREEN     = MAX_GREEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lamp,
  output phase_e     phase,
  output logic       err_lamp,
  output logic       err_seq,
  output logic       err_yellow,
  output logic       err_green
);

  phase_e     prev_q, prev_d;
  logic [7:0] dwell_q, dwell_d;
  logic       changed;

  always_comb begin
    phase   = decode_lamp(lamp);
    prev_d  = phase;
    changed = (phase != prev_q);

    // dwell counts cycles spent in the current phase, including its first.
    if (changed)                dwell_d = 8'd1;
    else if (dwell_q == 8'hFF)  dwell_d = dwell_q;
    else                        dwell_d = dwell_q + 8'd1;

    err_lamp = (phase == PH_DARK) || (phase == PH_ILLEGAL);

    err_seq = changed &&
              !((prev_q == PH_RED    && phase == PH_GREEN)  ||
                (prev_q == PH_GREEN  && phase == PH_YELLOW) ||
                (prev_q == PH_YELLOW && phase == PH_RED));

    // dwell_q still holds the length of the yellow period being left.
    err_yellow = (prev_q == PH_YELLOW) && (phase != PH_YELLOW) &&
                 (32'(dwell_q) != YELLOW_CYCLES);

    // Flag on the cycle whose sample would push green past its limit.
    err_green = (phase == PH_GREEN) && (32'(dwell_d) > MAX_GREEN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q  <= PH_RED;
      dwell_q <= 8'd0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/lamp_monitor.sv
// Supervises four traffic lights; arms on sustained all-red, latches the first sequencing fault.
// Latency: fault outputs register on the same edge that samples the offending lamps (1 cycle).
// Backpressure: none; fault is held until clear_fault, later failures ignored.
// Ports: clk, rst (sync, active-low), ltfs[3:0][2:0], clear_fault in;
//        armed, fault, fault_code[2:0], fault_light[1:0], attention, force_reds[3:0] out.
module lamp_monitor
  import tl_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES = YELLOW_CYCLES_DEF,
  parameter int unsigned MAX_GREEN     = MAX_GREEN_DEF,
  parameter int unsigned ARM_CYCLES    = ARM_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][2:0] ltfs,
  input  logic            clear_fault,
  output logic            armed,
  output logic            fault,
  output logic [2:0]      fault_code,
  output logic [1:0]      fault_light,
  output logic            attention,
  output logic [3:0]      force_reds
);

  phase_e     phase [4];
  logic [3:0] err_lamp, err_seq, err_yellow, err_green;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    lamp_channel #(
      .YELLOW_CYCLES(YELLOW_CYCLES),
      .MAX_GREEN    (MAX_GREEN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .lamp      (ltfs[i]),
      .phase     (phase[i]),
      .err_lamp  (err_lamp[i]),
      .err_seq   (err_seq[i]),
      .err_yellow(err_yellow[i]),
      .err_green (err_green[i])
    );
  end

  logic [3:0]  active;
  logic        conflict, all_red, fail;
  fault_code_e fail_code;
  logic [1:0]  fail_light;

  // Failure resolution: lowest code wins, then lowest light index.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      active[i] = (phase[i] == PH_GREEN) || (phase[i] == PH_YELLOW);
    end
    all_red = (phase[0] == PH_RED) && (phase[1] == PH_RED) &&
              (phase[2] == PH_RED) && (phase[3] == PH_RED);
    // Two or more bits set <=> clearing the lowest set bit leaves something.
    conflict = (active & (active - 4'd1)) != 4'd0;

    fail       = 1'b1;
    fail_code  = FC_NONE;
    fail_light = 2'd0;
    if (|err_lamp) begin
      fail_code = FC_LAMP;      fail_light = first_set(err_lamp);
    end else if (conflict) begin
      fail_code = FC_CONFLICT;  fail_light = first_set(active);
    end else if (|err_seq) begin
      fail_code = FC_SEQUENCE;  fail_light = first_set(err_seq);
    end else if (|err_yellow) begin
      fail_code = FC_YELLOW;    fail_light = first_set(err_yellow);
    end else if (|err_green) begin
      fail_code = FC_GREEN;     fail_light = first_set(err_green);
    end else begin
      fail = 1'b0;
    end
  end

  state_e      state_q, state_d;
  logic [7:0]  arm_cnt_q, arm_cnt_d;
  logic        fault_q, fault_d;
  fault_code_e code_q, code_d;
  logic [1:0]  light_q, light_d;
  logic        armed_q, armed_d;
  logic        attention_q, attention_d;
  logic [3:0]  force_q, force_d;

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    fault_d   = fault_q;
    code_d    = code_q;
    light_d   = light_q;

    case (state_q)
      ST_ARMING: begin
        if (!all_red)                arm_cnt_d = 8'd0;
        else if (arm_cnt_q != 8'hFF) arm_cnt_d = arm_cnt_q + 8'd1;
        // Entry is judged with the monitor checks on the entry edge; a failing
        // sample keeps us arming and restarts the count.
        if (32'(arm_cnt_q) >= ARM_CYCLES) begin
          if (fail) begin
            arm_cnt_d = 8'd0;
          end else begin
            state_d   = ST_MONITOR;
            arm_cnt_d = 8'd0;
          end
        end
      end
      ST_MONITOR: begin
        if (fail) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = fail_code;
          light_d = fail_light;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d   = ST_ARMING;
          arm_cnt_d = 8'd0;
          fault_d   = 1'b0;
          code_d    = FC_NONE;
          light_d   = 2'd0;
        end
      end
      default: state_d = ST_ARMING;
    endcase

    armed_d     = (state_d == ST_MONITOR);
    attention_d = (state_d == ST_FAULT);
    force_d     = (state_d == ST_MONITOR) ? 4'h0 : 4'hF;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ARMING;
      arm_cnt_q   <= 8'd0;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      light_q     <= 2'd0;
      armed_q     <= 1'b0;
      attention_q <= 1'b0;
      force_q     <= 4'hF;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      light_q     <= light_d;
      armed_q     <= armed_d;
      attention_q <= attention_d;
      force_q     <= force_d;
    end
  end

  assign armed       = armed_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_light = light_q;
  assign attention   = attention_q;
  assign force_reds  = force_q;

endmodule

// File: tb/tb_lamp_monitor.sv
// Directed bench for lamp_monitor: expected outputs queued per step, compared after each edge.
// Latency: every step expects the registered outputs one edge after driving.
// Backpressure: n/a.
module tb_lamp_monitor;

  logic            clk;
  logic            rst;
  logic [3:0][2:0] ltfs;
  logic            clear_fault;
  logic            armed, fault, attention;
  logic [2:0]      fault_code;
  logic [1:0]      fault_light;
  logic [3:0]      force_reds;

  lamp_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .ltfs       (ltfs),
    .clear_fault(clear_fault),
    .armed      (armed),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_light(fault_light),
    .attention  (attention),
    .force_reds (force_reds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       armed;
    logic       fault;
    logic [2:0] code;
    logic [1:0] light;
    logic       attn;
    logic [3:0] frc;
  } obs_t;

  localparam logic [2:0] R  = 3'b001;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b100;
  localparam logic [2:0] DK = 3'b000;

  localparam obs_t S_ARMING  = 12'b0_0_000_00_0_1111;
  localparam obs_t S_MONITOR = 12'b1_0_000_00_0_0000;

  obs_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic obs_t flt(input logic [2:0] c, input logic [1:0] li);
    flt = {1'b0, 1'b1, c, li, 1'b1, 4'hF};
  endfunction

  function automatic logic [11:0] lt(input logic [2:0] l0, input logic [2:0] l1,
                                     input logic [2:0] l2, input logic [2:0] l3);
    lt = {l3, l2, l1, l0};
  endfunction

  task automatic step(input logic [11:0] l, input logic clr, input logic r,
                      input obs_t e, input string tag);
    obs_t got, want;
    ltfs        = l;
    clear_fault = clr;
    rst         = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {armed, fault, fault_code, fault_light, attention, force_reds};
    want = exp_q.pop_front();
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  // Three all-red edges from a cleared count: armed after the third.
  task automatic rearm(input string tag);
    step(lt(R, R, R, R), 1'b0, 1'b1, S_ARMING,  tag);
    step(lt(R, R, R, R), 1'b0, 1'b1, S_ARMING,  tag);
    step(lt(R, R, R, R), 1'b0, 1'b1, S_MONITOR, tag);
  endtask

  task automatic clear_and_rearm(input string tag);
    step(lt(R, R, R, R), 1'b1, 1'b1, S_ARMING, {tag, "_clear"});
    rearm({tag, "_rearm"});
  endtask

  initial begin
    rst         = 1'b0;
    clear_fault = 1'b0;
    ltfs        = lt(R, R, R, R);

    // Reset state
    step(lt(R, R, R, R), 1'b0, 1'b0, S_ARMING, "reset_a");
    step(lt(R, R, R, R), 1'b0, 1'b0, S_ARMING, "reset_b");

    // Arming: armed on the third all-red edge
    rearm("arm");

    // Legal cycle on light 1
    for (int i = 0; i < 5; i++) step(lt(R, G, R, R), 1'b0, 1'b1, S_MONITOR, "l1_green");
    for (int i = 0; i < 2; i++) step(lt(R, Y, R, R), 1'b0, 1'b1, S_MONITOR, "l1_yellow");
    step(lt(R, R, R, R), 1'b0, 1'b1, S_MONITOR, "l1_red");

    // Conflict: lights 0 and 2 green together
    step(lt(G, R, G, R), 1'b0, 1'b1, flt(3'd2, 2'd0), "conflict");
    // Later failure while in FAULT does not overwrite the code
    step(lt(G, R, G, DK), 1'b0, 1'b1, flt(3'd2, 2'd0), "fault_hold");
    clear_and_rearm("recover1");

    // Skipped yellow on light 3
    step(lt(R, R, R, G), 1'b0, 1'b1, S_MONITOR, "l3_green");
    step(lt(R, R, R, R), 1'b0, 1'b1, flt(3'd3, 2'd3), "skip_yellow");
    clear_and_rearm("recover2");

    // Short yellow on light 2
    step(lt(R, R, G, R), 1'b0, 1'b1, S_MONITOR, "l2_green");
    step(lt(R, R, Y, R), 1'b0, 1'b1, S_MONITOR, "l2_yellow");
    step(lt(R, R, R, R), 1'b0, 1'b1, flt(3'd4, 2'd2), "short_yellow");
    clear_and_rearm("recover3");

    // Short yellow together with an illegal word on light 1: code 1 wins
    step(lt(R, R, G, R), 1'b0, 1'b1, S_MONITOR, "l2_green_b");
    step(lt(R, R, Y, R), 1'b0, 1'b1, S_MONITOR, "l2_yellow_b");
    step(lt(R, 3'b011, R, R), 1'b0, 1'b1, flt(3'd1, 2'd1), "illegal_wins");
    clear_and_rearm("recover4");

    // clear_fault outside FAULT has no effect
    step(lt(R, R, R, R), 1'b1, 1'b1, S_MONITOR, "clr_ignored");

    // Green dwell boundary: 15 cycles legal, 16th faults
    for (int i = 0; i < 15; i++) step(lt(G, R, R, R), 1'b0, 1'b1, S_MONITOR, "green_max");
    step(lt(G, R, R, R), 1'b0, 1'b1, flt(3'd5, 2'd0), "green_over");
    step(lt(R, R, R, R), 1'b1, 1'b1, S_ARMING, "recover5_clear");

    // Failure on the would-be entry edge keeps ARMING and restarts the count
    step(lt(R, R, R, R), 1'b0, 1'b1, S_ARMING, "entry_e1");
    step(lt(R, R, R, R), 1'b0, 1'b1, S_ARMING, "entry_e2");
    step(lt(DK, R, R, R), 1'b0, 1'b1, S_ARMING, "entry_fail");
    rearm("entry_rearm");

    // Reset mid-MONITOR
    step(lt(R, R, R, R), 1'b0, 1'b0, S_ARMING, "rst_monitor");
    rearm("rst_mon_rearm");

    // Reset mid-FAULT leaves nothing behind
    step(lt(G, R, G, R), 1'b0, 1'b1, flt(3'd2, 2'd0), "conflict_b");
    step(lt(R, R, R, R), 1'b0, 1'b0, S_ARMING, "rst_fault");
    rearm("rst_flt_rearm");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 SHALL have parameter YELLOW_CYCLES, default 2: exact yellow dwell, in cycles.
REQ-002 SHALL have parameter MAX_GREEN, default 15: longest legal green dwell, in cycles.
REQ-003 SHALL have parameter ARM_CYCLES, default 2: consecutive all-red cycles required to arm.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port ltfs  in  [3:0][2:0]  lamp outputs of lights 0-3; bit0 red, bit1 yellow, bit2 green.
REQ-007 SHALL have port clear_fault  in  1  single-cycle request to leave FAULT.
REQ-008 SHALL have port armed  out  1  high while in MONITOR.
REQ-009 SHALL have port fault  out  1  latched fault flag.
REQ-010 SHALL have port fault_code  out  3  first fault detected; 0 = none.
REQ-011 SHALL have port fault_light  out  2  index of the offending light.
REQ-012 SHALL have port attention  out  1  flashing-mode request to all lights.
REQ-013 SHALL have port force_reds  out  4  per-light force-red request.

Function
REQ-014 SHALL decode each light every cycle: 3'b001 RED, 3'b010 YELLOW, 3'b100 GREEN, 3'b000 DARK, any other value ILLEGAL.
REQ-015 SHALL keep one 8-bit dwell counter per light: load 1 on a phase change, otherwise increment, saturating at 255.
REQ-016 SHALL register each light's previous phase.
REQ-017 SHALL run FSM states ARMING, MONITOR and FAULT.
- ARMING -> MONITOR after ARM_CYCLES consecutive cycles with all four lights RED.
- MONITOR -> FAULT on any check failure.
- FAULT -> ARMING when clear_fault=1.
REQ-018 SHALL run these checks in MONITOR only, comparing the current ltfs input with the registered previous phase:
- code 1: ILLEGAL, or DARK;
- code 2: two or more lights GREEN or YELLOW;
- code 3: any transition other than RED->GREEN, GREEN->YELLOW or YELLOW->RED;
- code 4: YELLOW left with dwell != YELLOW_CYCLES;
- code 5: GREEN dwell would exceed MAX_GREEN.
REQ-019 SHALL resolve simultaneous failures by lowest code first, then lowest light index; code 2 reports the lowest-index conflicting light.
REQ-020 SHALL register fault, fault_code and fault_light on the same edge that samples the offending ltfs, giving 1-cycle latency.
REQ-021 SHALL hold fault_code and fault_light constant in FAULT, ignoring later failures.
REQ-022 SHALL drive attention=1 and force_reds=4'hF in FAULT.
REQ-023 SHALL drive attention=0 and force_reds=4'hF in ARMING.
REQ-024 SHALL drive attention=0 and force_reds=4'h0 in MONITOR.
REQ-025 SHALL, when clear_fault=1 in FAULT, clear fault, fault_code and fault_light on the next edge and enter ARMING.
REQ-026 SHALL ignore clear_fault outside FAULT.
REQ-027 SHALL restart the ARMING all-red count whenever any light is not RED.
REQ-028 SHALL give priority to a failure over entry into MONITOR when both occur on the same edge; the FSM stays in ARMING until a clean arm.

Reset
REQ-029 SHALL, while rst=0 at a clock edge, set the state to ARMING, clear the all-red count, set dwell counters to 0 and previous phases to RED.
REQ-030 SHALL reset outputs to armed=0, fault=0, fault_code=0, fault_light=0, attention=0, force_reds=4'hF.
REQ-031 SHALL abandon any in-progress fault or arming on reset mid-operation, with no residual state.

Structure
REQ-032 SHALL take the phase enum, fault-code enum, lamp bit positions and parameter defaults from shared package tl_pkg.
REQ-033 SHALL instantiate sub-module lamp_channel four times; each instance covers one light's decode, dwell counter, previous phase, and the code 1, 3, 4 and 5 checks.
REQ-034 SHALL perform the conflict check (code 2), fault priority and FSM in lamp_monitor.

Verification
REQ-035 SHALL cover arming: all RED for 2 cycles -> armed=1 and force_reds=0 on the 3rd edge.
REQ-036 SHALL cover a legal cycle on light 1: RED, GREEN x5, YELLOW x2, RED -> fault stays 0.
REQ-037 SHALL cover a conflict: lights 0 and 2 both GREEN in the same cycle -> next cycle fault=1, code=2, light=0, attention=1, force_reds=4'hF.
REQ-038 SHALL cover a skipped yellow: light 3 GREEN->RED -> code=3, light=3.
REQ-039 SHALL cover a short yellow and a simultaneous illegal code: light 2 YELLOW x1 then RED -> code=4; with light 1 at 3'b011 in the same cycle -> code=1, light=1.
REQ-040 SHALL cover recovery and reset: clear_fault in FAULT -> all fault outputs 0 and ARMING; rst=0 mid-MONITOR -> armed=0, force_reds=4'hF on the next edge.
